cmp_pipe: RTL and testbench

Parametrised, pipelined compare unit for the BETA ALU; next generation of the flag-based CMP block. It takes two operands directly, computes the A−B flags internally (Z, V, N, plus borrow C), and evaluates signed or unsigned compare functions. Results are returned as the standard 0/1 word. Valid/ready handshakes on both sides let it stall with the execute stage without losing operations.

---
 rtl/cmp_pipe_if.sv | 27 ++
 rtl/cmp_pipe.sv | 112 +++++++++++
 tb/tb_cmp_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_pipe_if.sv
// Operand/result handshake bundle for the cmp_pipe compare unit.
// master = execute stage side, slave = the compare unit.
interface cmp_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2:0]           fn;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] cmp;
  logic [3:0]           flags;
  logic                 err;

  modport master (
    output in_valid, a, b, fn, out_ready,
    input  in_ready, out_valid, cmp, flags, err
  );

  modport slave (
    input  in_valid, a, b, fn, out_ready,
    output in_ready, out_valid, cmp, flags, err
  );
endinterface

// File: rtl/cmp_pipe.sv
// Two-stage pipelined compare unit: stage 1 latches the A-B flags, stage 2
// evaluates the selected signed/unsigned condition into a 0/1 result word.
module cmp_pipe #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  cmp_pipe_if.slave  bus
);
  localparam logic [2:0] FN_EQ  = 3'b001;
  localparam logic [2:0] FN_LT  = 3'b010;
  localparam logic [2:0] FN_LE  = 3'b011;
  localparam logic [2:0] FN_NE  = 3'b100;
  localparam logic [2:0] FN_ULT = 3'b101;
  localparam logic [2:0] FN_ULE = 3'b110;

  logic       s1_valid_q, s1_valid_d;
  logic [3:0] s1_flags_q, s1_flags_d;
  logic [2:0] s1_fn_q,    s1_fn_d;
  logic       out_valid_q, out_valid_d;
  logic       cond_q,      cond_d;
  logic [3:0] flags_q,     flags_d;
  logic       err_q,       err_d;

  logic             s1_en, s2_en;
  logic [WIDTH:0]   diff;
  logic [3:0]       in_flags;
  logic             z1, v1, n1, c1;
  logic             cond, illegal;

  always_comb begin
    s2_en = ~out_valid_q | bus.out_ready;
    s1_en = ~s1_valid_q | s2_en;
  end

  // Flags of A-B, laid out {Z,V,N,C}; C is the borrow out of the extended subtract.
  always_comb begin
    diff     = {1'b0, bus.a} - {1'b0, bus.b};
    in_flags = {(diff[WIDTH-1:0] == '0),
                (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (diff[WIDTH-1] ^ bus.a[WIDTH-1]),
                diff[WIDTH-1],
                diff[WIDTH]};
  end

  always_comb begin
    {z1, v1, n1, c1} = s1_flags_q;
    cond    = 1'b0;
    illegal = 1'b0;
    case (s1_fn_q)
      FN_EQ:   cond = z1;
      FN_LT:   cond = n1 ^ v1;
      FN_LE:   cond = z1 | (n1 ^ v1);
      FN_NE:   cond = ~z1;
      FN_ULT:  cond = c1;
      FN_ULE:  cond = c1 | z1;
      default: illegal = 1'b1;
    endcase
  end

  // Payloads only load alongside a valid bit so undriven inputs never reach the outputs.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_flags_d  = s1_flags_q;
    s1_fn_d     = s1_fn_q;
    out_valid_d = out_valid_q;
    cond_d      = cond_q;
    flags_d     = flags_q;
    err_d       = err_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        cond_d  = cond;
        flags_d = s1_flags_q;
        err_d   = illegal;
      end
    end
    if (s1_en) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_flags_d = in_flags;
        s1_fn_d    = bus.fn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_flags_q  <= '0;
      s1_fn_q     <= '0;
      out_valid_q <= 1'b0;
      cond_q      <= 1'b0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_flags_q  <= s1_flags_d;
      s1_fn_q     <= s1_fn_d;
      out_valid_q <= out_valid_d;
      cond_q      <= cond_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = out_valid_q;
  assign bus.cmp       = {{(OUT_WIDTH-1){1'b0}}, cond_q};
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe: 32-bit and 8-bit instances, directed and random
// operations checked against an arithmetic reference model and FIFO scoreboard.
module tb_cmp_pipe;
  typedef struct packed {
    logic       cond;
    logic [3:0] flags;
    logic       err;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        vld;
  logic        ordy;
  logic [31:0] a_tb, b_tb;
  logic [2:0]  fn_tb;

  int     checks = 0;
  int     errors = 0;
  int     edges  = 0;
  entry_t q[$];

  cmp_pipe_if #(.WIDTH(32), .OUT_WIDTH(32)) if32 ();
  cmp_pipe_if #(.WIDTH(8),  .OUT_WIDTH(32)) if8 ();

  cmp_pipe #(.WIDTH(32), .OUT_WIDTH(32)) dut32 (.clk(clk), .reset(rst), .bus(if32.slave));
  cmp_pipe #(.WIDTH(8),  .OUT_WIDTH(32)) dut8  (.clk(clk), .reset(rst), .bus(if8.slave));

  assign if32.in_valid  = vld & ~sel;
  assign if32.a         = a_tb;
  assign if32.b         = b_tb;
  assign if32.fn        = fn_tb;
  assign if32.out_ready = ordy;
  assign if8.in_valid   = vld & sel;
  assign if8.a          = a_tb[7:0];
  assign if8.b          = b_tb[7:0];
  assign if8.fn         = fn_tb;
  assign if8.out_ready  = ordy;

  logic        obs_irdy, obs_ov, obs_err;
  logic [31:0] obs_cmp;
  logic [3:0]  obs_flags;
  assign obs_irdy  = sel ? if8.in_ready  : if32.in_ready;
  assign obs_ov    = sel ? if8.out_valid : if32.out_valid;
  assign obs_cmp   = sel ? if8.cmp       : if32.cmp;
  assign obs_flags = sel ? if8.flags     : if32.flags;
  assign obs_err   = sel ? if8.err       : if32.err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: compare the operands as true integers of the chosen width.
  function automatic res_t model(int w, logic [31:0] av, logic [31:0] bv, logic [2:0] f);
    longint m, ua, ub, sa, sb, d, wrap;
    res_t r;
    m    = longint'(1) << w;
    ua   = longint'({32'd0, av}) & (m - 1);
    ub   = longint'({32'd0, bv}) & (m - 1);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    d    = sa - sb;
    wrap = (ua - ub + m) % m;
    r.flags[3] = (ua == ub);
    r.flags[2] = (d >= m / 2) || (d < -(m / 2));
    r.flags[1] = (wrap >= m / 2);
    r.flags[0] = (ua < ub);
    r.err  = 1'b0;
    r.cond = 1'b0;
    case (f)
      3'd1: r.cond = (ua == ub);
      3'd2: r.cond = (sa < sb);
      3'd3: r.cond = (sa <= sb);
      3'd4: r.cond = (ua != ub);
      3'd5: r.cond = (ua < ub);
      3'd6: r.cond = (ua <= ub);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (w=%0d t=%0t): observed %h expected %h", tag, sel ? 8 : 32, $time, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, update scoreboard, advance past the edge.
  task automatic cycle(output bit acc);
    bit exp_rdy, exp_ov;
    acc = 1'b0;
    @(negedge clk);
    exp_rdy = (q.size() < 2) || ordy;
    exp_ov  = (q.size() > 0) && (edges >= q[0].acc + 1);
    chk("in_ready", {31'd0, obs_irdy}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, obs_ov}, {31'd0, exp_ov});
    if (exp_ov) begin
      chk("cmp", obs_cmp, {31'd0, q[0].r.cond});
      chk("flags", {28'd0, obs_flags}, {28'd0, q[0].r.flags});
      chk("err", {31'd0, obs_err}, {31'd0, q[0].r.err});
      if (ordy) void'(q.pop_front());
    end
    if (vld && exp_rdy) begin
      entry_t e;
      e.r   = model(sel ? 8 : 32, a_tb, b_tb, fn_tb);
      e.acc = edges + 1;
      q.push_back(e);
      acc = 1'b1;
    end
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic op(logic [31:0] av, logic [31:0] bv, logic [2:0] f);
    bit acc;
    int n;
    n = 0;
    vld = 1'b1; a_tb = av; b_tb = bv; fn_tb = f;
    do begin
      if (n > 3) ordy = 1'b1;
      cycle(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    vld = 1'b0;
  endtask

  task automatic idle(int n);
    bit acc;
    vld = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    vld = 1'b0; ordy = 1'b1;
    while (q.size() > 0 && n < 50) begin
      cycle(acc);
      n++;
    end
    chk("drain_left", q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b1;
    a_tb = $urandom; b_tb = $urandom; fn_tb = 3'b001;
    @(posedge clk);
    #1;
    edges++;
    rst = 1'b0; vld = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, obs_ov}, 32'd0);
    chk("rst_in_ready", {31'd0, obs_irdy}, 32'd1);
    chk("rst_cmp", obs_cmp, 32'd0);
    chk("rst_flags", {28'd0, obs_flags}, 32'd0);
    chk("rst_err", {31'd0, obs_err}, 32'd0);
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic run_suite();
    bit acc;
    logic [31:0] av, bv;
    ordy = 1'b1;
    op(32'd5, 32'd5, 3'b001);
    op(32'd5, 32'd6, 3'b001);
    op(32'hFFFF_FFFF, 32'd1, 3'b010);
    op(32'hFFFF_FFFF, 32'd1, 3'b101);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110);
    op(32'h8000_0000, 32'd1, 3'b010);
    op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b011);
    op(32'h0000_0080, 32'd1, 3'b010);
    op(32'h0000_0080, 32'd1, 3'b101);
    op(32'h0000_007F, 32'h0000_00FF, 3'b011);
    op(32'd3, 32'd9, 3'b000);
    op(32'd9, 32'd3, 3'b111);
    op(32'd9, 32'd3, 3'b100);
    drain();

    // Back-pressure: two held, third blocked for five cycles, then release.
    ordy = 1'b0;
    op(32'd7, 32'd7, 3'b001);
    op(32'd7, 32'd8, 3'b100);
    vld = 1'b1; a_tb = 32'hFFFF_FFF0; b_tb = 32'd2; fn_tb = 3'b010;
    for (int i = 0; i < 5; i++) cycle(acc);
    ordy = 1'b1;
    op(32'hFFFF_FFF0, 32'd2, 3'b010);
    op(32'd4, 32'd4, 3'b110);
    drain();

    // Random traffic with random stalls and bubbles.
    for (int i = 0; i < 150; i++) begin
      ordy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        av = $urandom;
        case ($urandom_range(0, 3))
          0: bv = av;
          1: begin
            av = (32'h8000_0000 >> ($urandom_range(0, 1) * 24)) - $urandom_range(0, 1);
            bv = (32'hFFFF_FFFF >> ($urandom_range(0, 1) * 24)) - $urandom_range(0, 1);
          end
          default: bv = $urandom;
        endcase
        op(av, bv, 3'($urandom_range(0, 7)));
      end
    end
    drain();

    // Reset with two operations in flight: nothing stale may emerge afterwards.
    ordy = 1'b0;
    op(32'd1, 32'd2, 3'b101);
    op(32'd2, 32'd1, 3'b101);
    do_reset();
    ordy = 1'b1;
    idle(4);
    op(32'd2, 32'd1, 3'b101);
    drain();
  endtask

  initial begin
    sel = 1'b0; vld = 1'b0; ordy = 1'b1; rst = 1'b1;
    a_tb = '0; b_tb = '0; fn_tb = '0;
    do_reset();
    run_suite();
    sel = 1'b1;
    do_reset();
    run_suite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
